// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state enum, bubble encoding, widths seen by decode.
package fetch_pkg;

    localparam int unsigned FETCH_PC_WIDTH   = 32;
    localparam int unsigned FETCH_INST_WIDTH = 32;
    localparam logic [FETCH_INST_WIDTH-1:0] FETCH_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline slot: load captures a fetched word, flush squashes, drain retires a consumed slot.
module if_id_reg #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter logic [INST_W-1:0] NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              drain,
    input  logic [PC_W-1:0]   load_pc,
    input  logic [INST_W-1:0] load_inst,
    input  logic              load_fault,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic [INST_W-1:0] inst,
    output logic              fault
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_plus4_q, pc_plus4_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP;
            fault_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            pc_d       = load_pc;
            pc_plus4_d = load_pc + PC_W'(4);
            inst_d     = load_inst;
            fault_d    = load_fault;
        end else if (drain) begin
            // fault flag stays up until the redirect that leaves FAULT
            valid_d = 1'b0;
            inst_d  = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            inst_q     <= NOP;
            fault_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
        end
    end

    assign valid    = valid_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign inst     = inst_q;
    assign fault    = fault_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC mux and RUN/FAULT control feeding the IF/ID slot.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned PCs; otherwise redirect targets are word-aligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH_LENGTH   = FETCH_PC_WIDTH,
    parameter int unsigned INST_WIDTH_LENGTH = FETCH_INST_WIDTH,
    parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC = '0,
    parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_addr,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [PC_WIDTH_LENGTH-1:0]   id_pc,
    output logic [PC_WIDTH_LENGTH-1:0]   id_pc_plus4,
    output logic [INST_WIDTH_LENGTH-1:0] id_inst,
    output logic                         id_fault
);

    localparam logic [PC_WIDTH_LENGTH-1:0] WORD_MASK = ~PC_WIDTH_LENGTH'(3);

    fetch_state_e state_q, state_d;
    logic [PC_WIDTH_LENGTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH_LENGTH-1:0]   redirect_target;
    logic [INST_WIDTH_LENGTH-1:0] slot_inst;
    logic slot_load, slot_flush, slot_drain, slot_fault, slot_free;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = redirect_pc & WORD_MASK;
`endif

    assign slot_free = !id_valid || id_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        slot_load  = 1'b0;
        slot_flush = 1'b0;
        slot_drain = 1'b0;
        slot_inst  = imem_inst;
        slot_fault = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    slot_flush = 1'b1;
                end else if (slot_free) begin
                    slot_load = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pc_q[1:0] != 2'b00) begin
                        slot_inst  = NOP_INST;
                        slot_fault = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        pc_d = pc_q + PC_WIDTH_LENGTH'(4);
                    end
`else
                    pc_d = pc_q + PC_WIDTH_LENGTH'(4);
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    slot_flush = 1'b1;
                    state_d    = RUN;
                end else if (id_ready) begin
                    slot_drain = 1'b1;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_q    <= RESET_PC;
`else
            pc_q    <= RESET_PC & WORD_MASK;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .PC_W   (PC_WIDTH_LENGTH),
        .INST_W (INST_WIDTH_LENGTH),
        .NOP    (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (slot_load),
        .flush      (slot_flush),
        .drain      (slot_drain),
        .load_pc    (pc_q),
        .load_inst  (slot_inst),
        .load_fault (slot_fault),
        .valid      (id_valid),
        .pc         (id_pc),
        .pc_plus4   (id_pc_plus4),
        .inst       (id_inst),
        .fault      (id_fault)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_fault;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_spc = '0;
    logic [31:0] m_inst = NOP;
    logic        m_fault = 1'b0;
    logic        m_trapped = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {12'hA5C, a[19:2], 2'b11};
    endfunction

    assign imem_inst = mem_word(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_inst        (id_inst),
        .id_fault       (id_fault)
    );

    // One clock: predict the next architectural state from the current inputs, then sample #1 after the edge.
    task automatic tick();
        logic [31:0] n_pc = m_pc;
        logic        n_valid = m_valid;
        logic [31:0] n_spc = m_spc;
        logic [31:0] n_inst = m_inst;
        logic        n_fault = m_fault;
        logic        n_trapped = m_trapped;
        logic [31:0] target = TRAP ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
        if (rst) begin
            n_pc = 32'h0; n_valid = 1'b0; n_spc = 32'h0; n_inst = NOP; n_fault = 1'b0; n_trapped = 1'b0;
        end else if (redirect_valid) begin
            n_pc = target; n_valid = 1'b0; n_inst = NOP; n_fault = 1'b0; n_trapped = 1'b0;
        end else if (m_trapped) begin
            if (id_ready) begin n_valid = 1'b0; n_inst = NOP; end
        end else if (!m_valid || id_ready) begin
            n_valid = 1'b1;
            n_spc = m_pc;
            if (m_pc % 4 == 0) begin
                n_inst = mem_word(m_pc); n_fault = 1'b0; n_pc = m_pc + 32'd4;
            end else begin
                n_inst = NOP; n_fault = 1'b1; n_trapped = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_valid = n_valid; m_spc = n_spc; m_inst = n_inst; m_fault = n_fault; m_trapped = n_trapped;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500; id_ready = 1'b0;
        tick();
        tick();
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", id_valid); end
        vectors++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h/%h want 0/0", id_pc, id_pc_plus4); end
        vectors++; if (id_inst !== NOP) begin miscompares++; $display("FAIL reset_inst got %h want %h", id_inst, NOP); end
        vectors++; if (id_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", id_fault); end
        redirect_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc = 32'(i * 4);
            tick();
            vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, id_valid); end
            vectors++; if (id_pc !== exp_pc) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", i, id_pc, exp_pc); end
            vectors++; if (id_pc_plus4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL stream_pc4[%0d] got %h want %h", i, id_pc_plus4, exp_pc + 32'd4); end
            vectors++; if (id_inst !== mem_word(exp_pc)) begin miscompares++; $display("FAIL stream_inst[%0d] got %h want %h", i, id_inst, mem_word(exp_pc)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (id_pc !== 32'h4 || id_inst !== mem_word(32'h4) || id_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold[%0d] got %h/%h/%b want 4/%h/1", i, id_pc, id_inst, id_valid, mem_word(32'h4)); end
            vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_addr[%0d] got %h want 8", i, imem_addr); end
        end
        id_ready = 1'b1;
        tick();
        vectors++; if (id_pc !== 32'h8 || id_inst !== mem_word(32'h8)) begin miscompares++; $display("FAIL stall_resume got %h/%h want 8/%h", id_pc, id_inst, mem_word(32'h8)); end
    endtask

    task automatic test_redirect_stalled();
        do_reset();
        tick();
        tick();
        id_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL redir_squash got %b want 0", id_valid); end
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr got %h want 100", imem_addr); end
        tick();
        vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== mem_word(32'h100)) begin
            miscompares++; $display("FAIL redir_slot got %b/%h/%h want 1/100/%h", id_valid, id_pc, id_inst, mem_word(32'h100)); end
        // redirect to the PC already held is still a squash
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = imem_addr;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h104) begin miscompares++; $display("FAIL redir_same got %b/%h want 0/104", id_valid, imem_addr); end
    endtask

    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0FFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        if (TRAP) begin
            vectors++; if (id_pc !== 32'h0FFF_FFFE || id_fault !== 1'b1 || id_inst !== NOP || id_valid !== 1'b1) begin
                miscompares++; $display("FAIL trap_slot got %h/%b/%h/%b want 0ffffffe/1/00000013/1", id_pc, id_fault, id_inst, id_valid); end
            tick();
            tick();
            vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h0FFF_FFFE) begin
                miscompares++; $display("FAIL trap_nofetch got %b/%h want 0/0ffffffe", id_valid, imem_addr); end
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
            tick();
            redirect_valid = 1'b0;
            vectors++; if (id_fault !== 1'b0) begin miscompares++; $display("FAIL trap_clear got %b want 0", id_fault); end
            tick();
            vectors++; if (id_pc !== 32'h200 || id_valid !== 1'b1) begin miscompares++; $display("FAIL trap_resume got %h/%b want 200/1", id_pc, id_valid); end
        end else begin
            vectors++; if (id_pc !== 32'h0FFF_FFFC || id_fault !== 1'b0 || id_inst !== mem_word(32'h0FFF_FFFC)) begin
                miscompares++; $display("FAIL align_slot got %h/%b/%h want 0ffffffc/0/%h", id_pc, id_fault, id_inst, mem_word(32'h0FFF_FFFC)); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        vectors++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_fault !== 1'b0) begin
            miscompares++; $display("FAIL wrap_last got %h/%h/%b want fffffffc/0/0", id_pc, id_pc_plus4, id_fault); end
        tick();
        vectors++; if (id_pc !== 32'h0 || id_inst !== mem_word(32'h0)) begin miscompares++; $display("FAIL wrap_first got %h want 0", id_pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            rst = ($urandom_range(0, 63) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc = r;
            id_ready = ($urandom_range(0, 3) != 0);
            tick();
            vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, m_pc); end
            vectors++; if (id_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b want %b", i, id_valid, m_valid); end
            vectors++; if (id_inst !== m_inst) begin miscompares++; $display("FAIL rnd_inst[%0d] got %h want %h", i, id_inst, m_inst); end
            vectors++; if (id_fault !== m_fault) begin miscompares++; $display("FAIL rnd_fault[%0d] got %b want %b", i, id_fault, m_fault); end
            if (m_valid) begin
                vectors++; if (id_pc !== m_spc || id_pc_plus4 !== m_spc + 32'd4) begin
                    miscompares++; $display("FAIL rnd_pc[%0d] got %h/%h want %h/%h", i, id_pc, id_pc_plus4, m_spc, m_spc + 32'd4); end
            end
        end
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stalled();
        test_misalign();
        test_wrap();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the fetch address to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register, using a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute, squashing the in-flight slot.

## Interface

Parameters:
- PC_WIDTH_LENGTH, 32, PC and fetch-address width
- INST_WIDTH_LENGTH, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  PC_WIDTH_LENGTH  fetch address to instruction memory; equals pc_q
- imem_inst  in  INST_WIDTH_LENGTH  instruction returned combinationally for imem_addr
- redirect_valid  in  1  execute requests a control-flow change
- redirect_pc  in  PC_WIDTH_LENGTH  redirect target
- id_ready  in  1  decode can accept the IF/ID slot this cycle
- id_valid  out  1  IF/ID slot holds a fetched instruction
- id_pc  out  PC_WIDTH_LENGTH  PC of slot instruction
- id_pc_plus4  out  PC_WIDTH_LENGTH  id_pc + 4, modulo 2^PC_WIDTH_LENGTH
- id_inst  out  INST_WIDTH_LENGTH  slot instruction; NOP_INST when not valid or faulted
- id_fault  out  1  slot is a misaligned-fetch fault (only with FETCH_MISALIGN_TRAP_EN)

## Operation

States: RUN, FAULT.
- Reset: state RUN; pc_q = RESET_PC; id_valid = 0; id_pc = 0; id_pc_plus4 = 0; id_inst = NOP_INST; id_fault = 0.

Slot free when `!id_valid || id_ready`.

In RUN, evaluated in priority order:
1. redirect_valid: pc_q <= redirect_pc; id_valid <= 0 (squash, even while stalled); state stays RUN.
2. Slot free and pc_q[1:0] == 0: load slot {pc_q, pc_q+4, imem_inst}, id_valid <= 1, id_fault <= 0; pc_q <= pc_q + 4.
3. Slot free and pc_q[1:0] != 0 (trap enabled): load slot {pc_q, pc_q+4, NOP_INST}, id_valid <= 1, id_fault <= 1; pc_q holds; go to FAULT.
4. Slot not free (stall): all registers hold.

In FAULT:
- No fetch. Slot drains normally: id_valid <= 0 when id_ready, otherwise holds.
- redirect_valid: pc_q <= redirect_pc; id_valid <= 0; id_fault <= 0; go to RUN.

Boundary conditions:
- pc_q + 4 wraps from 0xFFFF_FFFC to 0x0000_0000 with no fault.
- The address range is not checked; the memory decodes imem_addr[19:2].
- rst and redirect_valid in the same cycle: rst wins.
- Redirect to the address already in pc_q is still a squash.

## Timing

- Fetch to slot: 1 cycle. imem_inst is sampled the same cycle imem_addr presents pc_q.
- First valid slot appears the cycle after rst deasserts, with id_pc = RESET_PC.
- Redirect to target in slot: 2 cycles. Cycle N redirect; cycle N+1 slot invalid and imem_addr = target; cycle N+2 id_valid = 1 with id_pc = target.
- Sustained throughput: 1 instruction per cycle while id_ready = 1.
- No combinational path from id_ready or redirect_* to imem_addr; all outputs are registered.

## Configuration

- FETCH_MISALIGN_TRAP_EN defined: misaligned pc_q raises id_fault and enters FAULT as described.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is discarded (pc_q low bits forced to 0).
  - FAULT state and id_fault logic are removed; id_fault is tied to 0.

## Structure

- fetch_pkg holds:
  - the state enum (RUN, FAULT)
  - NOP_INST
  - the width constants shared with decode
- One sub-module, if_id_reg: holds the slot, with load, hold and flush controls.
- fetch_unit keeps pc_q, the state machine and the next-PC mux.

## Test plan

- Reset release, id_ready = 1, memory words 0..3 = A,B,C,D → slots A@0, B@4, C@8, D@0xC on consecutive cycles; id_pc_plus4 = id_pc + 4.
- Hold id_ready = 0 for 3 cycles after B@4 is presented → B@4 held stable and imem_addr held at 8; C@8 appears the cycle after id_ready returns.
- Redirect to 0x100 while stalled with B@4 → next cycle id_valid = 0 and imem_addr = 0x100; the following cycle the slot holds 0x100's instruction.
- Redirect to 0x0FFF_FFFE with trap enabled → slot id_pc = 0x0FFF_FFFE, id_fault = 1, id_inst = 0x0000_0013; no further fetch until a redirect to 0x200 resumes RUN.
- Same misaligned redirect with the macro undefined → fetch from 0x0FFF_FFFC, id_fault = 0.
- pc_q = 0xFFFF_FFFC → next slot id_pc = 0; rst asserted together with redirect_valid → all outputs return to reset values.
